mem_arbiter: RTL
================

# mem_arbiter

Shares one downstream memory port between the core's instruction-fetch requester (IFU) and load/store requester (LSU). Each requester issues single-cycle request pulses; the arbiter latches them, grants the bus to one requester at a time with round-robin fairness, and routes the response pulse and read data back to the owner. It sits between the core's `io_ifu_*`/`io_lsu_*` ports and the SoC memory interconnect, and has a watchdog that completes hung transactions with an error.

## Interface
- `TIMEOUT` (default 1024): number of BUSY cycles without `mem_respValid` before the watchdog fires. 0 disables the watchdog.
- `ERR_DATA` (default 32'hDEAD_BEEF): read data returned on a timed-out transaction.

- `clock`  in  1  sole clock. All state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `ifu_reqValid`  in  1  fetch request pulse.
- `ifu_addr`  in  32  fetch address, valid with `ifu_reqValid`.
- `ifu_respValid`  out  1  fetch completion pulse.
- `ifu_rdata`  out  32  fetched word, valid with `ifu_respValid`.
- `lsu_reqValid`  in  1  load/store request pulse.
- `lsu_addr`  in  32  data address.
- `lsu_size`  in  2  access size (0 = byte, 1 = half, 2 = word).
- `lsu_wen`  in  1  1 = store.
- `lsu_wdata`  in  32  store data.
- `lsu_wmask`  in  4  store byte mask.
- `lsu_respValid`  out  1  load/store completion pulse.
- `lsu_rdata`  out  32  load data, valid with `lsu_respValid`.
- `mem_reqValid`  out  1  downstream request pulse (1 cycle).
- `mem_addr`, `mem_size`, `mem_wen`, `mem_wdata`, `mem_wmask`  out  32/2/1/32/4  registered request fields. They are held stable for the whole transaction.
- `mem_respValid`  in  1  downstream completion pulse.
- `mem_rdata`  in  32  downstream read data.
- `err_drop`  out  1  sticky: a request arrived while that requester already had a request pending or in flight.
- `err_timeout`  out  1  sticky: the watchdog fired.

## Operation
- Per-requester pending slot: a valid bit plus the captured fields.
  - A request pulse captures into its slot on the edge.
  - The IFU slot stores size = 2, wen = 0, wmask = 0, wdata = 0.
- FSM states: IDLE, BUSY_IFU, BUSY_LSU.
- Grant candidates are a slot that is valid or a request pulse arriving this cycle. The incoming pulse bypasses the slot, so a request can be granted in the cycle it arrives.
- Arbitration when both requesters are candidates: round-robin. The requester not granted last wins. `last` resets to IFU, so LSU wins the first tie.
- On grant (state moves to BUSY_x):
  - `mem_reqValid` = 1 for exactly the next cycle.
  - `mem_*` fields load from the winner.
  - The winner's slot is cleared.
  - `last` is updated.
  - The watchdog counter is set to 0.
- In BUSY_x:
  - `x_respValid = mem_respValid`, combinational.
  - `x_rdata = mem_rdata`, combinational.
  - The other requester's `respValid` stays 0, and its `rdata` is 0.
- Completion on a `mem_respValid` cycle: the FSM arbitrates immediately among candidates, excluding the owner's pulse in that same cycle. The owner's new pulse is captured into its slot.
  - If a candidate exists, the FSM goes straight to BUSY_y (back-to-back grant).
  - Otherwise it returns to IDLE.
- Watchdog: in BUSY, the counter increments each cycle without a response. When it reaches `TIMEOUT - 1`:
  - `x_respValid` = 1 with `x_rdata` = `ERR_DATA` in that cycle.
  - `err_timeout` is set.
  - The FSM completes as above.
- `mem_respValid` in IDLE, or arriving after a timeout, is ignored and has no side effect.
- A request pulse for a requester whose slot is valid or that owns the bus is dropped. The slot is unchanged and `err_drop` is set.
- Reset values: all outputs 0, the FSM in IDLE, the slots empty, `last` = IFU, the counter 0, and the sticky errors clear. Reset mid-transaction abandons it: the next `mem_respValid` is ignored and no `respValid` is produced.

## Timing
- Request latency:
  - A request pulse at cycle t with the FSM in IDLE gives `mem_reqValid` high at t+1 only.
  - If the bus is busy, `mem_reqValid` is asserted the cycle after the owning transaction completes.
- Response latency: 0 cycles. `mem_respValid` at cycle r gives `x_respValid` at r.
- Back-to-back: with a pending request, the next `mem_reqValid` is at r+1. Sustained throughput is bounded only by memory latency.
- `mem_*` request fields are registered outputs. The `respValid`/`rdata` outputs are combinational from `mem_respValid`/`mem_rdata` and the state register.

## Test plan
- Single fetch:
  - Stimulus: `ifu_reqValid` at t with addr 0x8000_0000; `mem_respValid` at t+4 with `mem_rdata` 0x0000_0013.
  - Required: `mem_reqValid` at t+1 only, `mem_addr` 0x8000_0000, `mem_size` 2, `mem_wen` 0. `ifu_respValid` at t+4 with 0x13, and `lsu_respValid` stays 0.
- Simultaneous requests out of reset (IFU 0x100, LSU store to 0x200 with wmask 0xF):
  - Required: LSU is granted first. IFU's `mem_reqValid` follows in the cycle right after LSU's `mem_respValid`, with `mem_addr` 0x100.
- Fairness: both requesters re-request on every completion for 6 transactions -> grants alternate LSU, IFU, LSU, IFU, LSU, IFU.
- Drop: a second `lsu_reqValid` while LSU is in flight -> `err_drop` = 1, exactly one LSU transaction, and `mem_addr` is unchanged.
- Timeout with `TIMEOUT` = 8:
  - Stimulus: IFU request at t and no `mem_respValid`.
  - Required: `ifu_respValid` at t+8 with rdata 0xDEAD_BEEF and `err_timeout` = 1. A `mem_respValid` at t+10 produces no `respValid`.
- Reset mid-transaction: assert reset during BUSY_LSU, release it, then pulse `mem_respValid` -> all outputs 0 and no `lsu_respValid`. The next IFU request is serviced normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the IFU and LSU requesters.
// Watchdog completes hung transactions with ERR_DATA and flags err_timeout.
//
// state      | meaning
// S_IDLE     | no transaction in flight, bus free
// S_BUSY_IFU | IFU owns the bus, waiting for mem_respValid or watchdog
// S_BUSY_LSU | LSU owns the bus, waiting for mem_respValid or watchdog
module mem_arbiter #(
  parameter int unsigned TIMEOUT  = 1024,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ifu_reqValid,
  input  logic [31:0] ifu_addr,
  output logic        ifu_respValid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_reqValid,
  input  logic [31:0] lsu_addr,
  input  logic [1:0]  lsu_size,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_respValid,
  output logic [31:0] lsu_rdata,
  output logic        mem_reqValid,
  output logic [31:0] mem_addr,
  output logic [1:0]  mem_size,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_respValid,
  input  logic [31:0] mem_rdata,
  output logic        err_drop,
  output logic        err_timeout
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WDOG_TC = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY_IFU, S_BUSY_LSU} state_t;

  state_t        state, state_nxt;
  logic          ifu_pend, lsu_pend;
  logic [31:0]   ifu_addr_q, lsu_addr_q, lsu_wdata_q;
  logic [1:0]    lsu_size_q;
  logic          lsu_wen_q;
  logic [3:0]    lsu_wmask_q;
  logic          last_lsu;
  logic [CW-1:0] wdog;

  logic busy, fire, done;
  logic ifu_drop, lsu_drop, ifu_cand, lsu_cand;
  logic grant_ifu, grant_lsu;

  assign busy = (state != S_IDLE);
  assign fire = (TIMEOUT != 0) && busy && !mem_respValid && (wdog == WDOG_TC);
  assign done = busy && (mem_respValid || fire);

  // The owner's own pulse on its completion cycle is not a drop: it goes to the slot.
  assign ifu_drop = ifu_reqValid && (ifu_pend || (state == S_BUSY_IFU && !done));
  assign lsu_drop = lsu_reqValid && (lsu_pend || (state == S_BUSY_LSU && !done));
  assign ifu_cand = ifu_pend || (ifu_reqValid && !ifu_drop && state != S_BUSY_IFU);
  assign lsu_cand = lsu_pend || (lsu_reqValid && !lsu_drop && state != S_BUSY_LSU);

  always_comb begin
    state_nxt     = state;
    grant_ifu     = 1'b0;
    grant_lsu     = 1'b0;
    ifu_respValid = 1'b0;
    ifu_rdata     = 32'd0;
    lsu_respValid = 1'b0;
    lsu_rdata     = 32'd0;
    if (!busy || done) begin
      if (ifu_cand && lsu_cand) begin
        grant_lsu = !last_lsu;
        grant_ifu = last_lsu;
      end else begin
        grant_ifu = ifu_cand;
        grant_lsu = lsu_cand;
      end
      if (grant_ifu)      state_nxt = S_BUSY_IFU;
      else if (grant_lsu) state_nxt = S_BUSY_LSU;
      else                state_nxt = S_IDLE;
    end
    case (state)
      S_BUSY_IFU: begin
        ifu_respValid = done;
        ifu_rdata     = fire ? ERR_DATA : mem_rdata;
      end
      S_BUSY_LSU: begin
        lsu_respValid = done;
        lsu_rdata     = fire ? ERR_DATA : mem_rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      ifu_pend     <= 1'b0;
      ifu_addr_q   <= 32'd0;
      lsu_pend     <= 1'b0;
      lsu_addr_q   <= 32'd0;
      lsu_size_q   <= 2'd0;
      lsu_wen_q    <= 1'b0;
      lsu_wdata_q  <= 32'd0;
      lsu_wmask_q  <= 4'd0;
      last_lsu     <= 1'b0;
      wdog         <= '0;
      mem_reqValid <= 1'b0;
      mem_addr     <= 32'd0;
      mem_size     <= 2'd0;
      mem_wen      <= 1'b0;
      mem_wdata    <= 32'd0;
      mem_wmask    <= 4'd0;
      err_drop     <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      state        <= state_nxt;
      mem_reqValid <= grant_ifu || grant_lsu;
      err_drop     <= err_drop || ifu_drop || lsu_drop;
      err_timeout  <= err_timeout || fire;

      if (grant_ifu) begin
        ifu_pend <= 1'b0;
      end else if (ifu_reqValid && !ifu_drop) begin
        ifu_pend   <= 1'b1;
        ifu_addr_q <= ifu_addr;
      end

      if (grant_lsu) begin
        lsu_pend <= 1'b0;
      end else if (lsu_reqValid && !lsu_drop) begin
        lsu_pend    <= 1'b1;
        lsu_addr_q  <= lsu_addr;
        lsu_size_q  <= lsu_size;
        lsu_wen_q   <= lsu_wen;
        lsu_wdata_q <= lsu_wdata;
        lsu_wmask_q <= lsu_wmask;
      end

      // A pending slot always takes precedence over the same-cycle pulse (which is dropped).
      if (grant_ifu) begin
        mem_addr  <= ifu_pend ? ifu_addr_q : ifu_addr;
        mem_size  <= 2'd2;
        mem_wen   <= 1'b0;
        mem_wdata <= 32'd0;
        mem_wmask <= 4'd0;
        last_lsu  <= 1'b0;
      end else if (grant_lsu) begin
        mem_addr  <= lsu_pend ? lsu_addr_q  : lsu_addr;
        mem_size  <= lsu_pend ? lsu_size_q  : lsu_size;
        mem_wen   <= lsu_pend ? lsu_wen_q   : lsu_wen;
        mem_wdata <= lsu_pend ? lsu_wdata_q : lsu_wdata;
        mem_wmask <= lsu_pend ? lsu_wmask_q : lsu_wmask;
        last_lsu  <= 1'b1;
      end

      if (grant_ifu || grant_lsu) wdog <= '0;
      else if (busy && !done)     wdog <= wdog + 1'b1;
    end
  end

endmodule
